// File: rtl/wbc_vic_pkg.sv
// Shared definitions for the vectored interrupt controller: FSM state encoding
// and the "no source granted" marker reported on the active output.
package wbc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        ACK   = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [3:0] ACTIVE_NONE = 4'hF;
    localparam int         VEC_W       = 16;

endpackage

// File: rtl/wbc_vic_if.sv
// CPU interrupt-vector bus plus the peripheral request/acknowledge lines.
// The controller is the slave end; the CPU/peripheral side is the master.
interface wbc_vic_if #(
    parameter int N = 4
);
    logic [N-1:0] ireq;
    logic         virq;
    logic         istb;
    logic [15:0]  ivec;
    logic         iack;
    logic [N-1:0] dev_ack;
    logic [3:0]   active;

    modport master (
        output ireq,
        output istb,
        input  virq,
        input  ivec,
        input  iack,
        input  dev_ack,
        input  active
    );

    modport slave (
        input  ireq,
        input  istb,
        output virq,
        output ivec,
        output iack,
        output dev_ack,
        output active
    );
endinterface

// File: rtl/wbc_vic_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
// idx reads ACTIVE_NONE when nothing is requesting.
module prio_enc
    import wbc_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [3:0]   idx,
    output logic         any
);

    // Scan from the top so the lowest index is the last one to overwrite.
    always_comb begin
        idx = ACTIVE_NONE;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 4'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wbc_vic.sv
// Vectored interrupt controller: responder on the CPU vector bus with fixed
// priority arbitration, registered vector/acknowledge and per-device acks.
module wbc_vic
    import wbc_pkg::*;
#(
    parameter int                N        = 4,
    parameter logic [16*N-1:0]   VECTORS  = {16'o000070, 16'o000064, 16'o000060, 16'o000100},
    parameter logic [VEC_W-1:0]  SPURIOUS = 16'o000000
) (
    input  logic       clk_p,
    input  logic       rst_n,
    wbc_vic_if.slave   bus
);

    state_t             state_q, state_d;
    logic               virq_q, virq_d;
    logic               iack_q, iack_d;
    logic [VEC_W-1:0]   ivec_q, ivec_d;
    logic [N-1:0]       devAck_q, devAck_d;
    logic [3:0]         active_q, active_d;

    logic [3:0]         winIdx;
    logic               winAny;
    logic [VEC_W-1:0]   winVec;

    prio_enc #(.N(N)) u_prio (
        .req (bus.ireq),
        .idx (winIdx),
        .any (winAny)
    );

    always_comb begin
        winVec = SPURIOUS;
        for (int i = 0; i < N; i++) begin
            if (winIdx == 4'(i)) begin
                winVec = VECTORS[16*i +: 16];
            end
        end
    end

    // virq only follows ireq once the FSM has settled in IDLE, so the GAP
    // cycle and the first IDLE cycle give a granted device time to let go.
    always_comb begin
        state_d  = state_q;
        ivec_d   = ivec_q;
        active_d = active_q;
        devAck_d = '0;

        unique case (state_q)
            IDLE:    if (bus.istb) state_d = LATCH;
            LATCH:   state_d = ACK;
            ACK:     if (!bus.istb) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_q == LATCH) begin
            if (winAny) begin
                ivec_d   = winVec;
                active_d = winIdx;
                for (int i = 0; i < N; i++) begin
                    devAck_d[i] = (winIdx == 4'(i));
                end
            end else begin
                ivec_d   = SPURIOUS;
                active_d = ACTIVE_NONE;
            end
        end

        virq_d = (state_q == IDLE) && (state_d == IDLE) && (|bus.ireq);
        iack_d = (state_d == ACK);
    end

    always_ff @(posedge clk_p) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            virq_q   <= 1'b0;
            iack_q   <= 1'b0;
            ivec_q   <= 16'o000000;
            devAck_q <= '0;
            active_q <= ACTIVE_NONE;
        end else begin
            state_q  <= state_d;
            virq_q   <= virq_d;
            iack_q   <= iack_d;
            ivec_q   <= ivec_d;
            devAck_q <= devAck_d;
            active_q <= active_d;
        end
    end

    assign bus.virq    = virq_q;
    assign bus.iack    = iack_q;
    assign bus.ivec    = ivec_q;
    assign bus.dev_ack = devAck_q;
    assign bus.active  = active_q;

endmodule

// File: tb/tb_wbc_vic.sv
// Self-checking bench for wbc_vic: table of full vector-read transactions
// plus hand-written sequences for abort, late requests, reset and GAP timing.
module tb_wbc_vic;
    import wbc_pkg::*;

    localparam int N = 4;

    typedef struct packed {
        logic [3:0]  reqIdle;
        logic [3:0]  reqLatch;
        logic        expVirq;
        logic [15:0] expVec;
        logic [3:0]  expDevAck;
        logic [3:0]  expActive;
    } txn_t;

    logic clk_p = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    wbc_vic_if #(.N(N)) bus ();

    wbc_vic #(.N(N)) dut (
        .clk_p (clk_p),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk_p = ~clk_p;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0o, expected %0o", name, act, exp);
        end
    endtask

    // One complete transaction starting and ending in IDLE at a negedge.
    task automatic applyStimulus(input string tag, input txn_t t);
        bus.ireq = t.reqIdle;
        bus.istb = 1'b0;
        @(negedge clk_p);
        checkOutput({tag, " virq idle"}, 16'(bus.virq), 16'(t.expVirq));
        bus.ireq = t.reqLatch;
        bus.istb = 1'b1;
        @(negedge clk_p);
        checkOutput({tag, " virq latch"}, 16'(bus.virq), 16'd0);
        checkOutput({tag, " iack latch"}, 16'(bus.iack), 16'd0);
        @(negedge clk_p);
        checkOutput({tag, " iack"}, 16'(bus.iack), 16'd1);
        checkOutput({tag, " ivec"}, bus.ivec, t.expVec);
        checkOutput({tag, " dev_ack"}, 16'(bus.dev_ack), 16'(t.expDevAck));
        checkOutput({tag, " active"}, 16'(bus.active), 16'(t.expActive));
        @(negedge clk_p);
        checkOutput({tag, " iack hold"}, 16'(bus.iack), 16'd1);
        checkOutput({tag, " dev_ack once"}, 16'(bus.dev_ack), 16'd0);
        checkOutput({tag, " ivec hold"}, bus.ivec, t.expVec);
        bus.istb = 1'b0;
        bus.ireq = '0;
        @(negedge clk_p);
        checkOutput({tag, " iack gap"}, 16'(bus.iack), 16'd0);
        checkOutput({tag, " virq gap"}, 16'(bus.virq), 16'd0);
        @(negedge clk_p);
    endtask

    txn_t vecTable [6];

    initial begin
        // Source i owns slice [16*i+15:16*i], so source 0 is the last literal.
        vecTable[0] = '{4'b0100, 4'b0100, 1'b1, 16'o000064, 4'b0100, 4'd2};
        vecTable[1] = '{4'b1011, 4'b1011, 1'b1, 16'o000100, 4'b0001, 4'd0};
        vecTable[2] = '{4'b1010, 4'b1010, 1'b1, 16'o000060, 4'b0010, 4'd1};
        vecTable[3] = '{4'b0100, 4'b0000, 1'b1, 16'o000000, 4'b0000, ACTIVE_NONE};
        vecTable[4] = '{4'b1000, 4'b1000, 1'b1, 16'o000070, 4'b1000, 4'd3};
        vecTable[5] = '{4'b0000, 4'b0001, 1'b0, 16'o000100, 4'b0001, 4'd0};

        rst_n    = 1'b0;
        bus.ireq = '0;
        bus.istb = 1'b0;
        repeat (2) @(negedge clk_p);
        checkOutput("reset virq", 16'(bus.virq), 16'd0);
        checkOutput("reset iack", 16'(bus.iack), 16'd0);
        checkOutput("reset ivec", bus.ivec, 16'd0);
        checkOutput("reset dev_ack", 16'(bus.dev_ack), 16'd0);
        checkOutput("reset active", 16'(bus.active), 16'(ACTIVE_NONE));
        rst_n = 1'b1;
        @(negedge clk_p);

        for (int i = 0; i < 6; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecTable[i]);
        end

        // CPU abort: istb drops during LATCH, ACK still happens for one cycle.
        bus.ireq = 4'b0010;
        @(negedge clk_p);
        bus.istb = 1'b1;
        @(negedge clk_p);
        bus.istb = 1'b0;
        @(negedge clk_p);
        checkOutput("abort iack", 16'(bus.iack), 16'd1);
        checkOutput("abort dev_ack", 16'(bus.dev_ack), 16'b0010);
        checkOutput("abort ivec", bus.ivec, 16'o000060);
        bus.ireq = '0;
        @(negedge clk_p);
        checkOutput("abort iack gap", 16'(bus.iack), 16'd0);
        checkOutput("abort dev_ack gap", 16'(bus.dev_ack), 16'd0);
        @(negedge clk_p);

        // Late higher-priority request arrives during ACK.
        bus.ireq = 4'b1000;
        bus.istb = 1'b1;
        @(negedge clk_p);
        @(negedge clk_p);
        checkOutput("late ivec", bus.ivec, 16'o000070);
        bus.ireq = 4'b1001;
        @(negedge clk_p);
        checkOutput("late ivec hold", bus.ivec, 16'o000070);
        checkOutput("late active", 16'(bus.active), 16'd3);
        bus.istb = 1'b0;
        bus.ireq = 4'b0001;
        @(negedge clk_p);
        checkOutput("late iack gap", 16'(bus.iack), 16'd0);
        checkOutput("late ivec gap", bus.ivec, 16'o000070);
        @(negedge clk_p);
        applyStimulus("late2", '{4'b0001, 4'b0001, 1'b1, 16'o000100, 4'b0001, 4'd0});

        // Reset while iack is high.
        bus.ireq = 4'b0100;
        bus.istb = 1'b1;
        @(negedge clk_p);
        @(negedge clk_p);
        checkOutput("rstack iack pre", 16'(bus.iack), 16'd1);
        rst_n = 1'b0;
        @(negedge clk_p);
        checkOutput("rstack iack", 16'(bus.iack), 16'd0);
        checkOutput("rstack virq", 16'(bus.virq), 16'd0);
        checkOutput("rstack ivec", bus.ivec, 16'd0);
        checkOutput("rstack active", 16'(bus.active), 16'(ACTIVE_NONE));
        checkOutput("rstack dev_ack", 16'(bus.dev_ack), 16'd0);
        rst_n    = 1'b1;
        bus.istb = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_p);
            checkOutput($sformatf("rstack post dev_ack %0d", c), 16'(bus.dev_ack), 16'd0);
            checkOutput($sformatf("rstack post iack %0d", c), 16'(bus.iack), 16'd0);
        end
        checkOutput("rstack idle virq", 16'(bus.virq), 16'd1);
        bus.ireq = '0;
        repeat (2) @(negedge clk_p);

        // GAP suppression: device lingers one cycle, then drops.
        bus.ireq = 4'b0001;
        bus.istb = 1'b1;
        @(negedge clk_p);
        @(negedge clk_p);
        bus.istb = 1'b0;
        @(negedge clk_p);
        checkOutput("gapA virq gap", 16'(bus.virq), 16'd0);
        checkOutput("gapA iack gap", 16'(bus.iack), 16'd0);
        @(negedge clk_p);
        checkOutput("gapA virq idle0", 16'(bus.virq), 16'd0);
        bus.ireq = '0;
        @(negedge clk_p);
        checkOutput("gapA virq idle1", 16'(bus.virq), 16'd0);

        // GAP suppression: device keeps requesting, virq returns in IDLE.
        bus.ireq = 4'b0001;
        bus.istb = 1'b1;
        @(negedge clk_p);
        @(negedge clk_p);
        bus.istb = 1'b0;
        @(negedge clk_p);
        checkOutput("gapB virq gap", 16'(bus.virq), 16'd0);
        @(negedge clk_p);
        checkOutput("gapB virq idle0", 16'(bus.virq), 16'd0);
        @(negedge clk_p);
        checkOutput("gapB virq idle1", 16'(bus.virq), 16'd1);
        bus.ireq = '0;
        repeat (2) @(negedge clk_p);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
